// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - format codes, opcode constants and widths shared by the immediate generator
package imm_gen_pkg;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_C = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational instruction -> {imm, fmt, illegal} decoder
// IMM_GEN_CSR_EN enables zimm (Z) and CSR-address (C) immediates for SYSTEM opcodes.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  always_comb begin
    imm     = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OP_LOAD, OP_IMM, OP_JALR: begin
          fmt = FMT_I;
          imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
        end
        OP_IMM32: begin
          // word-sized ALU ops only exist on RV64
          if (XLEN == 64) begin
            fmt = FMT_I;
            imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
          end else begin
            illegal = 1'b1;
          end
        end
        OP_STORE: begin
          fmt = FMT_S;
          imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
        end
        OP_BRANCH: begin
          fmt = FMT_B;
          imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          fmt = FMT_U;
          imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
        end
        OP_JAL: begin
          fmt = FMT_J;
          imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        end
        OP_OP, OP_OP32, OP_FENCE: begin
        end
        OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
          if (inst[14]) begin
            fmt = FMT_Z;
            imm = {{(XLEN-5){1'b0}}, inst[19:15]};
          end else if (inst[13:12] != 2'b00) begin
            fmt = FMT_C;
            imm = {{(XLEN-12){1'b0}}, inst[31:20]};
          end
`else
`endif
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer and illegal counter
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [FMT_W-1:0] fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_illegal;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [FMT_W-1:0] skid_fmt;
  logic             skid_illegal;

  logic             accept;
  logic             drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      imm          <= '0;
      fmt          <= '0;
      illegal      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= '0;
      skid_illegal <= 1'b0;
      illegal_cnt  <= '0;
    end else begin
      // skid can only be full while in_ready is low, so it never competes with accept
      if (drain && skid_valid) begin
        imm        <= skid_imm;
        fmt        <= skid_fmt;
        illegal    <= skid_illegal;
        skid_valid <= 1'b0;
      end else if (accept && (drain || !out_valid)) begin
        imm       <= dec_imm;
        fmt       <= dec_fmt;
        illegal   <= dec_illegal;
        out_valid <= 1'b1;
      end else if (accept) begin
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
        skid_valid   <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      if (accept && dec_illegal && (illegal_cnt != '1)) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake and classifies its format from the opcode. Produces the sign/zero-extended XLEN-wide immediate one cycle later through a 2-entry skid buffer, so the fetch/decode boundary can absorb back-pressure without a combinational ready path. Also flags unsupported opcodes and keeps a saturating count of them.

## Interface
- XLEN, 32: datapath width of `imm`; legal values 32 or 64.
- CNT_W, 8: width of the illegal-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  `inst` is valid.
- in_ready  out  1  block can accept; equals NOT skid_valid (register-driven, no combinational path from `out_ready`).
- inst  in  32  instruction word.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output entry.
- imm  out  XLEN  generated immediate.
- fmt  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 C (CSR address).
- illegal  out  1  opcode not supported.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Accept on rising edge when in_valid && in_ready.
- Illegal cases:
  - inst[1:0] != 2'b11 → illegal.
  - Opcode not in the decode list → illegal.
  - Illegal entries carry fmt R and imm 0.
- Decode (S = inst[31] replicated to XLEN):
  - 0000011, 0010011, 1100111 → I: {S, inst[31:20]}.
  - 0011011 → I, only when XLEN=64; illegal when XLEN=32.
  - 0100011 → S: {S, inst[31:25], inst[11:7]}.
  - 1100011 → B: {S, inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0110111, 0010111 → U: {S, inst[31:12], 12'b0}.
  - 1101111 → J: {S, inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 0110011, 0111011, 0001111 → R, imm 0.
  - 1110011 (SYSTEM) → see Configuration.
- Buffering:
  - Main register holds the presented entry; skid register holds one overflow entry.
  - Accept while main is full and not draining → entry goes to skid; in_ready deasserts next cycle.
  - Main drains (out_ready) while skid is full → skid moves to main the same edge; in_ready reasserts next cycle.
  - Simultaneous accept and drain with skid empty → new entry replaces main directly.
  - Order is strictly FIFO; no loss, no duplication.
- Counter:
  - Increments by 1 on each accepted illegal instruction.
  - Holds at all-ones (2^CNT_W − 1), never wraps.

## Timing
- Latency: 1 cycle from accept to out_valid, with out_ready held high.
- Throughput: 1 instruction per cycle with out_ready high.
- Output stability: imm, fmt and illegal stay stable while out_valid && !out_ready.
- Reset values: out_valid 0, skid_valid 0 (so in_ready 1), imm 0, fmt 0, illegal 0, illegal_cnt 0.
- Reset mid-operation: buffered entries are discarded, and inputs presented in the same cycle as rst are ignored.
- Reset release: first accept is possible in the cycle after rst falls.

## Configuration
- IMM_GEN_CSR_EN:
  - Defined:
    - SYSTEM with funct3[2]=1 → fmt Z, imm = zero-extended inst[19:15].
    - SYSTEM with funct3 in {1,2,3} → fmt C, imm = zero-extended inst[31:20].
    - SYSTEM with funct3=0 → fmt R, imm 0.
  - Undefined: every SYSTEM instruction → fmt R, imm 0, illegal 0. Codes 6 and 7 are never produced.

## Structure
- Package imm_gen_pkg holds:
  - The fmt enum (3 bits).
  - Opcode localparams.
  - A FMT_W constant.
- Sub-module imm_decode: purely combinational, instruction → {imm, fmt, illegal}.
- Top-level imm_gen_pipe: skid buffer, handshake logic and counter.

## Test plan
- ADDI, inst 0xFFF00093, XLEN=32 → next cycle out_valid=1, fmt I, imm 0xFFFFFFFF, illegal 0.
- BEQ −4, inst 0xFE000EE3 → fmt B, imm 0xFFFFFFFC.
- LUI:
  - inst 0x123452B7 → fmt U, imm 0x12345000.
  - XLEN=64, inst 0x800002B7 → imm 0xFFFFFFFF80000000.
- Back-pressure:
  - out_ready=0, issue ADDI, BEQ, LUI back-to-back → in_ready low after the 2nd accept; 3rd is held.
  - Then out_ready=1 → outputs appear in order, each exactly once.
  - Assert rst with both entries full → out_valid=0 and in_ready=1 the next cycle.
- Illegal counting:
  - inst 0x00000000 → illegal=1, imm 0, illegal_cnt 1.
  - 300 illegal instructions with CNT_W=8 → illegal_cnt holds at 255.
- CSRRWI, inst 0x3052D073:
  - With IMM_GEN_CSR_EN → fmt Z, imm 5.
  - Without → fmt R, imm 0, illegal 0.
